orb_frame_rx: RTL and testbench
===============================

# orb_frame_rx

Receive side of the Orbita M8 serial telemetry link. Deserialises the 12-bit word stream produced by the frame former (serial bit plus word-valid), acquires and tracks frame sync on a marker word, and writes each received word with its in-frame address into a frame buffer (same 12-bit data / 10-bit address shape as the group buffers). It is the checking and loop-back end of the frame former. It sits on the bench or ground-side board, and on the same FPGA for self-test.

## Interface
Parameters:
- WORDS, 1024: words per frame, 2..1024; slot addresses 0..WORDS-1.
- MARKER, 12'h7E5: sync word expected in slot 0 of every frame.
- CONFIRM, 2: consecutive correctly spaced markers (including the first) required to lock; 2..15.
- MISS_MAX, 2: consecutive missing markers that drop lock; 1..15.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; priority over every other input.
- iBitEn  in  1  bit strobe, one clk per serial bit.
- iSerial  in  1  serial data, sampled when iBitEn=1.
- iValid  in  1  word-valid; high for all 12 bits of a word.
- oData  out  12  received word.
- oAddr  out  10  slot index of oData within the frame.
- oWrEn  out  1  one-clk write strobe for oData/oAddr.
- oLocked  out  1  frame sync held.
- oFrameStart  out  1  one-clk pulse when a locked frame's marker is accepted.
- oSyncErr  out  8  missed-marker count while locked; saturates at 255.
- oShortErr  out  8  aborted-word count; saturates at 255.

## Operation
- Reset: every output is 0. The shift register, bit counter, slot counter, hit counter and miss counter are cleared. FSM goes to HUNT.
- Deserialiser:
  - On iBitEn=1 with iValid=1, shift iSerial in MSB first and increment the bit counter (0..11).
  - At count 11, the word is complete. Latch it as wordReady, then reset the counter.
  - iBitEn=1 with iValid=0 and counter≠0: discard the partial word, clear the counter, and increment oShortErr.
  - iBitEn=1 with iValid=0 and counter=0: no action.
  - iBitEn=0: hold everything, whatever iValid is.
- Slot counter: advances once per completed word and wraps from WORDS-1 to 0. Slot-0 words are "marker slots".
- FSM, evaluated only on completed words:
  - HUNT:
    - word==MARKER: go to CHECK, set slot:=1 for the next word, hits:=1.
    - Otherwise stay in HUNT.
    - No writes.
  - CHECK:
    - Non-marker-slot words are counted only.
    - At a marker slot with word==MARKER: hits+1. When hits reaches CONFIRM, go to LOCK; this marker is written (addr 0) and oFrameStart pulses.
    - At a marker slot with word≠MARKER: go to HUNT with hits:=0.
    - No writes except that locking marker.
  - LOCK:
    - Every word is written with oAddr=slot.
    - Marker slot with word==MARKER: miss:=0 and oFrameStart pulses.
    - Marker slot with word≠MARKER: miss+1 and oSyncErr+1.
    - When miss reaches MISS_MAX: go to HUNT, oLocked:=0, miss:=0. The failing word is not written.
    - A failing marker below MISS_MAX is still written at addr 0.
- oLocked=1 exactly while in LOCK.
- The counters oSyncErr and oShortErr are never cleared except by reset.

## Timing
- Write latency: oWrEn, oData, oAddr and oFrameStart are registered. They are valid in the clk cycle after the clk that sampled bit 0 (LSB). oData/oAddr hold until the next write.
- oLocked rises together with the first oWrEn/oFrameStart of the locking marker. It falls one clk after the sampling of the LSB of the MISS_MAX-th bad marker.
- Minimum iBitEn spacing is 1 clk. Back-to-back words, with iValid held high across the boundary, must be accepted without loss.
- An aborted word does not advance the slot counter.
- Reset asserted mid-word or mid-frame: the next clk shows all outputs at 0. No write occurs from pre-reset data.

## Test plan
- Lock: stream 3 frames of WORDS=1024, marker 12'h7E5 at slot 0, slot n carrying n[11:0].
  - Required: oLocked rises at frame 2 slot 0.
  - First oWrEn has oAddr=0, oData=12'h7E5, with oFrameStart.
  - Frame 3 writes slots 0..1023 with data=addr and no errors.
- False marker: 12'h7E5 at slot 5 of a random frame, with the true marker missing at spacing.
  - Required: CHECK falls back to HUNT, no oWrEn, oLocked stays 0.
- Loss of lock (MISS_MAX=2): once locked, corrupt two consecutive markers to 12'h000.
  - First: written at addr 0, oSyncErr=1, still locked.
  - Second: not written, oSyncErr=2, oLocked=0.
- Short word: drop iValid after 5 bits.
  - Required: oShortErr=1, slot counter unchanged, next full word written at the expected address.
- Bit-rate extremes: iBitEn every clk, then every 8 clks with random gaps.
  - Required: identical written data, and oWrEn exactly 1 clk after each LSB sample.
- Reset mid-frame: assert reset at slot 300 while locked.
  - Required: all outputs 0 the next clk, and relock only after CONFIRM fresh markers.

Source files
------------

// File: rtl/orb_frame_rx.sv
// orb_frame_rx: receive end of the Orbita M8 telemetry link.
// Deserialises the 12-bit word stream, acquires/tracks frame sync on a
// marker word in slot 0 and emits each received word with its in-frame
// slot address for a frame buffer.
module orb_frame_rx #(
   parameter int          WORDS    = 1024,
   parameter logic [11:0] MARKER   = 12'h7E5,
   parameter int          CONFIRM  = 2,
   parameter int          MISS_MAX = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iBitEn,
   input  logic        iSerial,
   input  logic        iValid,
   output logic [11:0] oData,
   output logic [9:0]  oAddr,
   output logic        oWrEn,
   output logic        oLocked,
   output logic        oFrameStart,
   output logic [7:0]  oSyncErr,
   output logic [7:0]  oShortErr
);

   localparam logic [9:0] LAST_SLOT   = 10'(WORDS - 1);
   localparam logic [3:0] CONFIRM_CNT = 4'(CONFIRM);
   localparam logic [3:0] MISS_CNT    = 4'(MISS_MAX);

   typedef enum logic [1:0] {
      HUNT,
      CHECK,
      LOCK
   } state_t;

   state_t      state;
   logic [10:0] shift_reg;   // first 11 bits of the word in flight
   logic [3:0]  bit_cnt;     // bits already received of the current word
   logic [9:0]  slot;        // slot index the next completed word lands in
   logic [3:0]  hits;        // correctly spaced markers seen while in CHECK
   logic [3:0]  miss;        // consecutive bad markers while in LOCK

   // The word completes on the clk that samples its LSB, so the FSM works on
   // the word assembled combinationally from the shift register and iSerial.
   logic [11:0] word;
   logic        word_last;
   logic        word_done;
   logic        is_marker;
   logic        marker_slot;
   logic [9:0]  slot_next;

   assign word        = {shift_reg, iSerial};
   assign word_last   = (bit_cnt == 4'd11);
   assign word_done   = iBitEn && iValid && word_last;
   assign is_marker   = (word == MARKER);
   assign marker_slot = (slot == 10'd0);
   assign slot_next   = (slot == LAST_SLOT) ? 10'd0 : slot + 10'd1;

   // Deserialiser, slot counter, sync FSM and registered write port.
   // NOTE: every register here uses <= so all updates see pre-edge values;
   // mixing in = would make results depend on statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= HUNT;
         shift_reg   <= '0;
         bit_cnt     <= '0;
         slot        <= '0;
         hits        <= '0;
         miss        <= '0;
         oData       <= '0;
         oAddr       <= '0;
         oWrEn       <= 1'b0;
         oLocked     <= 1'b0;
         oFrameStart <= 1'b0;
         oSyncErr    <= '0;
         oShortErr   <= '0;
      end else begin
         // Strobes are single-cycle; a write below re-asserts them.
         oWrEn       <= 1'b0;
         oFrameStart <= 1'b0;

         if (iBitEn) begin
            if (iValid) begin
               shift_reg <= word[10:0];
               bit_cnt   <= word_last ? 4'd0 : bit_cnt + 4'd1;
            end else if (bit_cnt != 4'd0) begin
               // Word aborted mid-flight: drop it without touching the slot.
               bit_cnt <= 4'd0;
               if (oShortErr != 8'hFF) oShortErr <= oShortErr + 8'd1;
            end
         end

         if (word_done) begin
            slot <= slot_next;
            case (state)
               HUNT: begin
                  if (is_marker) begin
                     state <= CHECK;
                     slot  <= 10'd1;
                     hits  <= 4'd1;
                  end
               end
               CHECK: begin
                  if (marker_slot) begin
                     if (!is_marker) begin
                        state <= HUNT;
                        hits  <= 4'd0;
                     end else if (hits + 4'd1 == CONFIRM_CNT) begin
                        state       <= LOCK;
                        hits        <= 4'd0;
                        miss        <= 4'd0;
                        oLocked     <= 1'b1;
                        oWrEn       <= 1'b1;
                        oFrameStart <= 1'b1;
                        oAddr       <= 10'd0;
                        oData       <= word;
                     end else begin
                        hits <= hits + 4'd1;
                     end
                  end
               end
               LOCK: begin
                  if (marker_slot && !is_marker) begin
                     if (oSyncErr != 8'hFF) oSyncErr <= oSyncErr + 8'd1;
                     if (miss + 4'd1 == MISS_CNT) begin
                        // Lock lost: the failing marker is not written.
                        state   <= HUNT;
                        miss    <= 4'd0;
                        oLocked <= 1'b0;
                     end else begin
                        miss  <= miss + 4'd1;
                        oWrEn <= 1'b1;
                        oAddr <= slot;
                        oData <= word;
                     end
                  end else begin
                     if (marker_slot) begin
                        miss        <= 4'd0;
                        oFrameStart <= 1'b1;
                     end
                     oWrEn <= 1'b1;
                     oAddr <= slot;
                     oData <= word;
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_orb_frame_rx.sv
// Directed bench for orb_frame_rx with a short frame (WORDS=16) so that
// lock, loss of lock, false markers, short words, slow bit rates and reset
// all fit in a few thousand clocks. Slot n carries n, slot 0 the marker.
module tb_orb_frame_rx;

   localparam int          WORDS    = 16;
   localparam logic [11:0] MARKER   = 12'h7E5;
   localparam int          CONFIRM  = 2;
   localparam int          MISS_MAX = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        iBitEn;
   logic        iSerial;
   logic        iValid;
   logic [11:0] oData;
   logic [9:0]  oAddr;
   logic        oWrEn;
   logic        oLocked;
   logic        oFrameStart;
   logic [7:0]  oSyncErr;
   logic [7:0]  oShortErr;

   int total  = 0;
   int bad    = 0;
   int wr_seen = 0;
   int wr_exp  = 0;
   bit slow    = 1'b0;

   orb_frame_rx #(
      .WORDS(WORDS), .MARKER(MARKER), .CONFIRM(CONFIRM), .MISS_MAX(MISS_MAX)
   ) dut (
      .clk(clk), .reset(reset), .iBitEn(iBitEn), .iSerial(iSerial),
      .iValid(iValid), .oData(oData), .oAddr(oAddr), .oWrEn(oWrEn),
      .oLocked(oLocked), .oFrameStart(oFrameStart), .oSyncErr(oSyncErr),
      .oShortErr(oShortErr)
   );

   always #5 clk = ~clk;

   // Count write strobes mid-cycle; a strobe wider than one clk shows up
   // as an extra write against the expected total.
   always @(negedge clk) if (oWrEn === 1'b1) wr_seen++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are read 1 time unit after
   // the rising edge that sampled the bit.
   task automatic drive_bit(input logic b, input logic v, input logic en);
      @(negedge clk);
      iSerial = b;
      iValid  = v;
      iBitEn  = en;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive_bit(1'b0, 1'b0, 1'b0);
   endtask

   // Send the top n bits of w, MSB first; slow mode inserts 1..8 idle clks
   // (random iValid/iSerial, iBitEn low) ahead of every bit.
   task automatic send_bits(input logic [11:0] w, input int n);
      for (int i = 11; i > 11 - n; i--) begin
         if (slow) repeat ($urandom_range(1, 8))
            drive_bit(1'($urandom), 1'($urandom), 1'b0);
         drive_bit(w[i], 1'b1, 1'b1);
      end
   endtask

   // Send one full word and check the outputs one clk after its LSB.
   task automatic word_exp(input string tag, input logic [11:0] w, input logic ew,
                           input logic [9:0] ea, input logic efs, input logic el);
      send_bits(w, 12);
      check({tag, " wr"}, oWrEn, ew);
      if (ew) begin
         wr_exp++;
         check({tag, " addr"}, oAddr, ea);
         check({tag, " data"}, oData, w);
      end
      check({tag, " fs"}, oFrameStart, efs);
      check({tag, " lock"}, oLocked, el);
   endtask

   // Slots from..WORDS-1 carrying their own index.
   task automatic frame_rest(input string tag, input int from, input logic ew, input logic el);
      for (int n = from; n < WORDS; n++)
         word_exp($sformatf("%s s%0d", tag, n), 12'(n), ew, 10'(n), 1'b0, el);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " data"},  oData, 12'h000);
      check({tag, " addr"},  oAddr, 10'd0);
      check({tag, " wr"},    oWrEn, 1'b0);
      check({tag, " lock"},  oLocked, 1'b0);
      check({tag, " fs"},    oFrameStart, 1'b0);
      check({tag, " sync"},  oSyncErr, 8'd0);
      check({tag, " short"}, oShortErr, 8'd0);
   endtask

   initial begin
      reset   = 1'b1;
      iBitEn  = 1'b0;
      iValid  = 1'b0;
      iSerial = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      @(negedge clk);
      reset = 1'b0;
      idle(2);

      // Acquire: frame 1 marker enters CHECK, frame 2 marker locks.
      word_exp("f1 s0", MARKER, 1'b0, 10'd0, 1'b0, 1'b0);
      frame_rest("f1", 1, 1'b0, 1'b0);
      word_exp("f2 s0", MARKER, 1'b1, 10'd0, 1'b1, 1'b1);
      frame_rest("f2", 1, 1'b1, 1'b1);
      word_exp("f3 s0", MARKER, 1'b1, 10'd0, 1'b1, 1'b1);
      frame_rest("f3", 1, 1'b1, 1'b1);
      check("f3 sync", oSyncErr, 8'd0);
      check("f3 short", oShortErr, 8'd0);

      // Loss of lock: first bad marker written, second drops lock unwritten.
      word_exp("f4 s0 bad", 12'h000, 1'b1, 10'd0, 1'b0, 1'b1);
      check("f4 sync", oSyncErr, 8'd1);
      frame_rest("f4", 1, 1'b1, 1'b1);
      word_exp("f5 s0 bad", 12'h000, 1'b0, 10'd0, 1'b0, 1'b0);
      check("f5 sync", oSyncErr, 8'd2);
      frame_rest("f5", 1, 1'b0, 1'b0);

      // False marker at slot 5, nothing at its spacing: CHECK falls back.
      word_exp("fa s0", 12'h000, 1'b0, 10'd0, 1'b0, 1'b0);
      for (int n = 1; n < 5; n++)
         word_exp($sformatf("fa s%0d", n), 12'(n), 1'b0, 10'd0, 1'b0, 1'b0);
      word_exp("fa s5 false", MARKER, 1'b0, 10'd0, 1'b0, 1'b0);
      frame_rest("fa", 6, 1'b0, 1'b0);
      word_exp("fb s0", 12'h000, 1'b0, 10'd0, 1'b0, 1'b0);
      frame_rest("fb", 1, 1'b0, 1'b0);
      // Real markers afterwards must acquire from HUNT in two frames.
      word_exp("fc s0", MARKER, 1'b0, 10'd0, 1'b0, 1'b0);
      frame_rest("fc", 1, 1'b0, 1'b0);
      word_exp("fd s0", MARKER, 1'b1, 10'd0, 1'b1, 1'b1);

      // Short word after slot 2: counted, slot counter unchanged.
      frame_rest("fd", 1, 1'b1, 1'b1);
      word_exp("fe s0", MARKER, 1'b1, 10'd0, 1'b1, 1'b1);
      word_exp("fe s1", 12'd1, 1'b1, 10'd1, 1'b0, 1'b1);
      word_exp("fe s2", 12'd2, 1'b1, 10'd2, 1'b0, 1'b1);
      send_bits(12'd3, 5);
      drive_bit(1'b0, 1'b0, 1'b1);
      check("abort short", oShortErr, 8'd1);
      check("abort wr", oWrEn, 1'b0);
      frame_rest("fe", 3, 1'b1, 1'b1);
      check("fe sync", oSyncErr, 8'd2);

      // Slow bit rate with random gaps: same writes, same latency.
      slow = 1'b1;
      word_exp("slow s0", MARKER, 1'b1, 10'd0, 1'b1, 1'b1);
      frame_rest("slow", 1, 1'b1, 1'b1);
      slow = 1'b0;

      // Reset mid-word while locked, then relock needs CONFIRM markers.
      word_exp("ff s0", MARKER, 1'b1, 10'd0, 1'b1, 1'b1);
      for (int n = 1; n < 10; n++)
         word_exp($sformatf("ff s%0d", n), 12'(n), 1'b1, 10'(n), 1'b0, 1'b1);
      send_bits(12'd10, 6);
      @(negedge clk);
      reset  = 1'b1;
      iBitEn = 1'b0;
      iValid = 1'b0;
      @(posedge clk);
      #1;
      check_idle_outputs("midreset");
      @(negedge clk);
      reset = 1'b0;
      frame_rest("ff post", 11, 1'b0, 1'b0);
      word_exp("fg s0", MARKER, 1'b0, 10'd0, 1'b0, 1'b0);
      frame_rest("fg", 1, 1'b0, 1'b0);
      word_exp("fh s0", MARKER, 1'b1, 10'd0, 1'b1, 1'b1);
      check("fh sync", oSyncErr, 8'd0);
      check("fh short", oShortErr, 8'd0);

      idle(3);
      check("write count", wr_seen, wr_exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
